// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the device:
// clock inhibit, request-to-send, start/data/parity/stop bits clocked out
// by the device, then the device ACK bit. Open-drain pins are driven
// through the *_oe outputs (1 = pull low).
//
// Handshake: a byte is accepted on the rising clk25 edge where tx_valid and
// tx_ready are both high. tx_ready is high only in IDLE when no done pulse
// is being shown; tx_valid while busy is dropped, not queued. done is a
// one-cycle pulse and err is valid with it, holding until the next accept.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk25,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam int unsigned FW = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0] FLT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [15:0]   INH_LAST  = 16'(INHIBIT_CYCLES - 1);
    localparam logic [15:0]   INH_DATA  = 16'(INHIBIT_CYCLES - 2);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    // Input conditioning state
    logic          c_s1_q, c_s2_q, d_s1_q, d_s2_q;
    logic          c_filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          fall_q;

    // Transmit FSM state
    state_t       state_q, state_d;
    logic [8:0]   sh_q, sh_d;
    logic [3:0]   edge_q, edge_d;
    logic [15:0]  inh_q, inh_d;
    logic [15:0]  to_q, to_d;
    logic         nack_q, nack_d;
    logic         err_q, err_d;
    logic         done_q, done_d;
    logic         c_oe_q, c_oe_d;
    logic         d_oe_q, d_oe_d;

    logic         timeout;
    logic [3:0]   edge_inc;

    // Synchronize both pins; accept a new clock level only after FILTER_LEN
    // consecutive samples disagree with the current one, strobing fall on 1->0.
    always_ff @(posedge clk25) begin
        if (!resetn) begin
            c_s1_q    <= 1'b1;
            c_s2_q    <= 1'b1;
            d_s1_q    <= 1'b1;
            d_s2_q    <= 1'b1;
            c_filt_q  <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            c_s1_q <= ps2c_in;
            c_s2_q <= c_s1_q;
            d_s1_q <= ps2d_in;
            d_s2_q <= d_s1_q;
            fall_q <= 1'b0;
            if (c_s2_q == c_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                c_filt_q  <= c_s2_q;
                flt_cnt_q <= '0;
                fall_q    <= ~c_s2_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    // FSM and datapath registers; reset releases both lines immediately.
    always_ff @(posedge clk25) begin
        if (!resetn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            edge_q  <= '0;
            inh_q   <= '0;
            to_q    <= '0;
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            edge_q  <= edge_d;
            inh_q   <= inh_d;
            to_q    <= to_d;
            nack_q  <= nack_d;
            err_q   <= err_d;
            done_q  <= done_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
        end
    end

    assign timeout  = (to_q == TO_LAST);
    assign edge_inc = (edge_q == 4'd11) ? 4'd11 : edge_q + 4'd1;

    // Next-state logic: inhibit timing, bit shifting on device clock falls,
    // ACK sampling and the watchdog that aborts a stalled frame.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        edge_d  = edge_q;
        inh_d   = inh_q;
        to_d    = to_q;
        nack_d  = nack_q;
        err_d   = err_q;
        done_d  = 1'b0;
        c_oe_d  = c_oe_q;
        d_oe_d  = d_oe_q;
        case (state_q)
            IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                inh_d  = '0;
                to_d   = '0;
                edge_d = '0;
                if (tx_valid && tx_ready) begin
                    sh_d    = {~^tx_data, tx_data};
                    err_d   = 1'b0;
                    nack_d  = 1'b0;
                    c_oe_d  = 1'b1;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                inh_d = inh_q + 16'd1;
                // start bit goes low in the final inhibit cycle
                if (inh_q == INH_DATA) d_oe_d = 1'b1;
                if (inh_q == INH_LAST) begin
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b1;
                    to_d    = '0;
                    state_d = RTS;
                end
            end
            default: begin
                to_d = fall_q ? 16'd0 : to_q + 16'd1;
                if (timeout) begin
                    // a fall in the same cycle loses to the timeout
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    case (state_q)
                        RTS, SHIFT: begin
                            if (fall_q) begin
                                edge_d = edge_inc;
                                if (edge_q == 4'd9) begin
                                    d_oe_d  = 1'b0;   // stop bit: release data
                                    state_d = ACK;
                                end else begin
                                    d_oe_d  = ~sh_q[0];
                                    sh_d    = {1'b1, sh_q[8:1]};
                                    state_d = SHIFT;
                                end
                            end
                        end
                        ACK: begin
                            if (fall_q) begin
                                nack_d  = d_s2_q;
                                edge_d  = edge_inc;
                                state_d = WAIT_IDLE;
                            end
                        end
                        WAIT_IDLE: begin
                            if (c_filt_q && d_s2_q) begin
                                err_d   = nack_q;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    assign tx_ready    = (state_q == IDLE) && !done_q;
    assign busy        = (state_q != IDLE) || done_q;
    assign done        = done_q;
    assign err         = err_q;
    assign ps2c_oe     = c_oe_q;
    assign ps2d_oe     = d_oe_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain lines, random
// command bytes, and a scoreboard checked whenever done pulses.
module tb_ps2_host_tx;

    localparam int INH = 2500;
    localparam int TMO = 4000;
    localparam int W   = 12;   // {timeout, err, check_bits, parity, data[7:0]}

    logic       clk25 = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, err;
    logic       ps2c_oe, ps2d_oe;
    logic [2:0] dbg_state;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       ps2c_in, ps2d_in;

    assign ps2c_in = ~(ps2c_oe | dev_c_low);
    assign ps2d_in = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(8)
    ) dut (
        .clk25(clk25),
        .resetn(resetn),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .err(err),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    always #20 clk25 = ~clk25;
    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [8:0]   rx_bits = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // reference model: the 9 bits the device must see, parity odd over all
    function automatic logic [8:0] model_bits(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic tick(input int k);
        repeat (k) @(posedge clk25);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [W-1:0] expv, input bit push);
        if (push) exp_q.push_back(expv);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // device: waits out the inhibit, then clocks 11 edges at half period h
    task automatic dev_frame(input int h, input bit nack, input bit stall,
                             input int abort_edge, input bit inject);
        int n = 0;
        while (ps2c_oe !== 1'b1 && n < 100) begin tick(1); n++; end
        if (ps2c_oe !== 1'b1) begin check("inhibit_start_seen", 32'd0, 32'd1); return; end
        n = 0;
        while (ps2c_oe === 1'b1 && n < INH + 100) begin tick(1); n++; end
        if (ps2c_oe === 1'b1) begin check("inhibit_end_seen", 32'd0, 32'd1); return; end
        if (stall) return;
        check("start_bit", 32'(ps2d_in), 32'd0);
        tick(h);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && !nack) dev_d_low = 1'b1;
            dev_c_low = 1'b1;
            tick(h);
            if (e == abort_edge) begin
                resetn = 1'b0;
                tick(1);
                @(negedge clk25);
                check("reset_c_oe", 32'(ps2c_oe), 32'd0);
                check("reset_d_oe", 32'(ps2d_oe), 32'd0);
                check("reset_tx_ready", 32'(tx_ready), 32'd1);
                @(posedge clk25);
                #1;
                resetn = 1'b1;
                dev_c_low = 1'b0;
                return;
            end
            if (inject && e == 3) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                tick(2);
                tx_valid = 1'b0;
            end
            if (e <= 9) rx_bits[e-1] = ps2d_in;
            if (e == 10) begin
                check("stop_line_high", 32'(ps2d_in), 32'd1);
                check("stop_released", 32'(ps2d_oe), 32'd0);
            end
            dev_c_low = 1'b0;
            tick(h);
            if (e == 11) dev_d_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int prev, input int budget);
        int n = 0;
        while (done_cnt == prev && n < budget) begin tick(1); n++; end
        if (done_cnt == prev) check("done_within_budget", 32'd0, 32'd1);
    endtask

    // monitor / scoreboard
    int   c_run = 0;
    int   rts_cyc = 0;
    logic d_prev1 = 1'b0, d_prev2 = 1'b0;
    bit   in_frame = 0, busy_bad = 0;
    always @(negedge clk25) begin
        if (!resetn) begin
            c_run = 0;
            in_frame = 0;
            busy_bad = 0;
        end else begin
            if (ps2c_oe) c_run++;
            else begin
                if (c_run > 0) begin
                    check("inhibit_len", 32'(c_run), 32'(INH));
                    check("start_one_cycle_early", {30'd0, d_prev2, d_prev1}, 32'd1);
                    rts_cyc = cyc;
                end
                c_run = 0;
            end
            d_prev2 = d_prev1;
            d_prev1 = ps2d_oe;
            if (in_frame && !busy) busy_bad = 1;
            if (done) begin
                logic [W-1:0] e;
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_at_done", 32'(err), 32'(e[10]));
                    check("busy_through_frame", {30'd0, busy, ~busy_bad}, 32'd3);
                    check("lines_released", {30'd0, ps2c_oe, ps2d_oe}, 32'd0);
                    if (e[9]) check("device_rx_bits", 32'(rx_bits), 32'(e[8:0]));
                    if (e[11]) check("timeout_latency", 32'(cyc - rts_cyc), 32'(TMO));
                end
                in_frame = 0;
                busy_bad = 0;
            end
            if (tx_valid && tx_ready) in_frame = 1;
        end
    end

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] d;
        int h;
        bit nk;
        // reset block
        tick(5);
        @(negedge clk25);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
        check("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
        @(posedge clk25);
        #1;
        resetn = 1'b1;
        tick(20);

        // 0xED with ACK
        base = done_cnt;
        send(8'hED, {3'b001, model_bits(8'hED)}, 1);
        dev_frame(40, 0, 0, 0, 0);
        wait_done(base, 2000);
        tick(20);

        // 0xF4 with a dropped 0xAA mid-frame
        base = done_cnt;
        send(8'hF4, {3'b001, model_bits(8'hF4)}, 1);
        dev_frame(40, 0, 0, 0, 1);
        wait_done(base, 2000);
        tick(300);
        check("one_done_for_f4", 32'(done_cnt - base), 32'd1);
        check("aa_not_sent", 32'(ps2c_oe), 32'd0);

        // NACK
        base = done_cnt;
        send(8'h55, {3'b011, model_bits(8'h55)}, 1);
        dev_frame(30, 1, 0, 0, 0);
        wait_done(base, 2000);
        tick(20);

        // device never clocks
        base = done_cnt;
        send(8'hF4, {3'b110, 9'd0}, 1);
        dev_frame(30, 0, 1, 0, 0);
        wait_done(base, TMO + 500);
        tick(20);

        // reset during edge 5, then 0xFF completes
        base = done_cnt;
        send(8'hED, '0, 0);
        dev_frame(40, 0, 0, 5, 0);
        tick(200);
        check("no_done_after_reset", 32'(done_cnt), 32'(base));
        base = done_cnt;
        send(8'hFF, {3'b001, model_bits(8'hFF)}, 1);
        dev_frame(40, 0, 0, 0, 0);
        wait_done(base, 2000);
        tick(20);

        // random bytes, speeds and ACK/NACK
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom_range(0, 255));
            h  = int'($urandom_range(20, 60));
            nk = ($urandom_range(0, 3) == 0);
            base = done_cnt;
            send(d, {1'b0, nk, 1'b1, model_bits(d)}, 1);
            dev_frame(h, nk, 0, 0, 0);
            wait_done(base, 2000);
            tick(int'($urandom_range(5, 40)));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
